gray_to_binary_code: RTL and testbench
======================================

// Module: gray_to_binary_code
// PURPOSE
//  - Converts a WIDTH-bit reflected Gray code word into its natural binary value.
//  - The output is registered: one clock of latency, with a valid qualifier.
//  - Sits behind Gray-coded sources such as encoders or async-FIFO pointers.
//  - Feeds binary consumers: comparators, arithmetic, debug monitors.
// PARAMETERS
//  - WIDTH  4  bit width of the gray and binary words (legal range 2..32)
// PORTS
//  - clk        in   1      single clock; all state updates on rising edge
//  - rst_n      in   1      reset, synchronous and active-low, sampled on clk rising edge
//  - in_valid   in   1      gray is valid this cycle
//  - gray       in   WIDTH  Gray-coded input word
//  - out_valid  out  1      binary holds a new result this cycle
//  - binary     out  WIDTH  converted natural binary word (registered)
//  - step_err   out  1      illegal Gray step flag; present only with the macro below
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, binary=0, step_err=0; reference register cleared.
//  - Conversion: binary[WIDTH-1] = gray[WIDTH-1].
//  - For i = WIDTH-2 down to 0: binary[i] = binary[i+1] ^ gray[i].
//  - Equivalently, binary[i] is the XOR of gray[WIDTH-1:i].
//  - Latency: in_valid sampled high at edge N gives binary and out_valid=1 after edge N.
//  - Results remain visible for exactly one cycle.
//  - in_valid=0 at an edge: out_valid drops to 0 and binary holds its last value.
//  - There is no backpressure. A new word is accepted every cycle; throughput is 1 word/clk.
//  - Reset has priority over in_valid. A word presented during reset is discarded and not output.
//  - All 2^WIDTH codes are legal inputs and the mapping is a bijection.
//  - Boundaries: all-zeros maps to all-zeros; a lone MSB set (1000) maps to all-ones (1111).
//  - All-ones input (1111) maps to 1010 for WIDTH=4.
//  - No X propagation from idle inputs: binary only loads when in_valid=1.
// CONFIGURATION
//  - Macro GRAY_TO_BINARY_CODE_STEP_CHECK_EN.
//  - Defined: the block stores the last accepted gray word plus a "have_ref" bit.
//    - On each accepted word with have_ref=1, it computes the Hamming distance to the stored word.
//    - step_err=1 (same cycle as out_valid) when the distance is >=2; otherwise 0.
//    - Distance 0 (repeat) and distance 1 are legal.
//    - The first word after reset is never flagged.
//    - Wrap-around (MSB-only code back to zero, e.g. 1000->0000) is a legal single step.
//    - step_err clears to 0 on any cycle without an accepted word.
//  - Undefined: the step_err port, the stored word and the compare logic are absent.
//    Conversion timing is identical in both builds.
// TESTING
//  - Exhaustive sweep: WIDTH=4, gray 0000..1111 one per cycle with in_valid=1.
//    binary matches the XOR-prefix model one cycle later, e.g. 0010->0011, 0111->0101, 1101->1001.
//  - Boundaries: gray=0000 -> 0000; 1000 -> 1111; 1111 -> 1010; each out_valid=1 for one cycle.
//  - Idle hold: 0110 (->0100), then in_valid=0 for 3 cycles -> out_valid=0, binary stays 0100.
//  - Reset mid-stream: rst_n=0 while in_valid=1, gray=0101 -> next cycle out_valid=0, binary=0000.
//  - Step check (macro on): sequence 0000,0001,0011,0000.
//    step_err=0,0,0,1 (last step has distance 2); then 1000->0000 gives step_err=0.
//  - Parameter sweep: WIDTH=8, gray 8'b1000_0000 -> 8'b1111_1111; 8'b1111_1111 -> 8'b1010_1010.

Source files
------------

// File: rtl/gray_to_binary_code.sv
// -----------------------------------------------------------------------------
// gray_to_binary_code
//
// Purpose:
//    Converts a WIDTH-bit reflected Gray code word into its natural binary
//    value. The result is registered, so it appears one clock after the word
//    is accepted and is qualified by out_valid for exactly one cycle. There is
//    no backpressure: one word per clock.
//
// Optional feature:
//    Define GRAY_TO_BINARY_CODE_STEP_CHECK_EN to add a step checker. It keeps
//    the last accepted Gray word and raises step_err alongside out_valid when
//    a new word differs from it in two or more bit positions. The first word
//    after reset is never flagged.
//
// Parameters:
//    WIDTH      width of the gray and binary words (2..32)
//
// Ports:
//    clk        clock, all state updates on the rising edge
//    rst_n      synchronous active-low reset
//    in_valid   gray holds a word to convert this cycle
//    gray       Gray-coded input word
//    out_valid  binary holds a fresh result this cycle
//    binary     converted natural binary word, holds when no word is accepted
//    step_err   illegal Gray step flag (only with the step checker enabled)
// -----------------------------------------------------------------------------
module gray_to_binary_code #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] gray,
   output logic             out_valid,
   output logic [WIDTH-1:0] binary
`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
   ,
   output logic             step_err
`endif
);

   // Each binary bit is the XOR of all Gray bits at and above its position,
   // built from the MSB downwards as a running prefix.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b            = '0;
      b[WIDTH-1]   = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] binary_q;
   logic [WIDTH-1:0] binary_d;

   // Next-state for the conversion result: load only on an accepted word so
   // idle (possibly undriven) inputs never reach the output register.
   always_comb begin
      valid_d  = in_valid;
      binary_d = binary_q;
      if (in_valid) begin
         binary_d = gray2bin(gray);
      end else begin
         binary_d = binary_q;
      end
   end

   // Result and qualifier registers; reset wins over an incoming word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         binary_q <= '0;
      end else begin
         valid_q  <= valid_d;
         binary_q <= binary_d;
      end
   end

   assign out_valid = valid_q;
   assign binary    = binary_q;

`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
   // Number of set bits; 6 bits covers the largest legal WIDTH of 32.
   function automatic logic [5:0] popcount(input logic [WIDTH-1:0] v);
      logic [5:0] cnt;
      cnt = 6'd0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

   logic [WIDTH-1:0] ref_q;
   logic [WIDTH-1:0] ref_d;
   logic             have_ref_q;
   logic             have_ref_d;
   logic             step_err_q;
   logic             step_err_d;

   // Next-state for the step checker: compare against the previous accepted
   // word (if any), then make the current word the new reference. A repeat
   // (distance 0) and a single-bit change, including wrap-around, are legal.
   always_comb begin
      ref_d      = ref_q;
      have_ref_d = have_ref_q;
      step_err_d = 1'b0;
      if (in_valid) begin
         ref_d      = gray;
         have_ref_d = 1'b1;
         if (have_ref_q && (popcount(gray ^ ref_q) >= 6'd2)) begin
            step_err_d = 1'b1;
         end else begin
            step_err_d = 1'b0;
         end
      end else begin
         ref_d      = ref_q;
         have_ref_d = have_ref_q;
         step_err_d = 1'b0;
      end
   end

   // Step checker registers; reset forgets the reference so the first word
   // after reset cannot be flagged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_q      <= '0;
         have_ref_q <= 1'b0;
         step_err_q <= 1'b0;
      end else begin
         ref_q      <= ref_d;
         have_ref_q <= have_ref_d;
         step_err_q <= step_err_d;
      end
   end

   assign step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_to_binary_code.sv
module tb_gray_to_binary_code;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid;
   logic [3:0] gray;
   logic       out_valid;
   logic [3:0] binary;

   logic       in_valid8;
   logic [7:0] gray8;
   logic       out_valid8;
   logic [7:0] binary8;

`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
   logic       step_err;
   logic       step_err8;
`endif

   int checks = 0;
   int errors = 0;

   // Hand-computed Gray -> binary table for WIDTH=4, indexed by the Gray code.
   logic [3:0] exp_tbl [16] = '{
      4'd0,  4'd1,  4'd3,  4'd2,  4'd7,  4'd6,  4'd4,  4'd5,
      4'd15, 4'd14, 4'd12, 4'd13, 4'd8,  4'd9,  4'd11, 4'd10
   };

   gray_to_binary_code #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .gray      (gray),
      .out_valid (out_valid),
      .binary    (binary)
`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
      ,
      .step_err  (step_err)
`endif
   );

   gray_to_binary_code #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .gray      (gray8),
      .out_valid (out_valid8),
      .binary    (binary8)
`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
      ,
      .step_err  (step_err8)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word on the 4-bit DUT at the falling edge, then return just
   // after the rising edge that captures it.
   task automatic drive(input logic v, input logic [3:0] g);
      @(negedge clk);
      in_valid = v;
      gray     = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      gray      = 4'd0;
      in_valid8 = 1'b0;
      gray8     = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_vld", {31'd0, out_valid}, 32'd0);
      check_eq("rst_bin", {28'd0, binary}, 32'd0);
      check_eq("rst_vld8", {31'd0, out_valid8}, 32'd0);
      check_eq("rst_bin8", {24'd0, binary8}, 32'd0);
`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
      check_eq("rst_err", {31'd0, step_err}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive sweep, one word per clock.
      for (int i = 0; i < 16; i++) begin
         logic [3:0] g;
         g = 4'(i);
         drive(1'b1, g);
         check_eq("sweep_bin", {28'd0, binary}, {28'd0, exp_tbl[i]});
         check_eq("sweep_vld", {31'd0, out_valid}, 32'd1);
      end

      // Boundaries, each followed by an idle cycle to show one-cycle validity.
      drive(1'b1, 4'b1000);
      check_eq("msb_bin", {28'd0, binary}, {28'd0, 4'b1111});
      check_eq("msb_vld", {31'd0, out_valid}, 32'd1);
      drive(1'b0, 4'b1000);
      check_eq("msb_vld_drop", {31'd0, out_valid}, 32'd0);
      check_eq("msb_hold", {28'd0, binary}, {28'd0, 4'b1111});
      drive(1'b1, 4'b1111);
      check_eq("ones_bin", {28'd0, binary}, {28'd0, 4'b1010});
      check_eq("ones_vld", {31'd0, out_valid}, 32'd1);
      drive(1'b0, 4'b1111);
      check_eq("ones_vld_drop", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 4'b0000);
      check_eq("zero_bin", {28'd0, binary}, 32'd0);
      check_eq("zero_vld", {31'd0, out_valid}, 32'd1);
      drive(1'b0, 4'b0000);
      check_eq("zero_vld_drop", {31'd0, out_valid}, 32'd0);

      // Idle hold: binary keeps its value while inputs wander.
      drive(1'b1, 4'b0110);
      check_eq("hold_load", {28'd0, binary}, {28'd0, 4'b0100});
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 4'(4'b1111 - k));
         check_eq("hold_vld", {31'd0, out_valid}, 32'd0);
         check_eq("hold_bin", {28'd0, binary}, {28'd0, 4'b0100});
      end

      // Reset mid-stream: the presented word is discarded.
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      gray     = 4'b0101;
      @(posedge clk);
      #1;
      check_eq("midrst_vld", {31'd0, out_valid}, 32'd0);
      check_eq("midrst_bin", {28'd0, binary}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("postrst_vld", {31'd0, out_valid}, 32'd0);

`ifdef GRAY_TO_BINARY_CODE_STEP_CHECK_EN
      // Step checker after reset: 0000,0001,0011,0000 then 1000,0000.
      drive(1'b1, 4'b0000);
      check_eq("step_first", {31'd0, step_err}, 32'd0);
      drive(1'b1, 4'b0001);
      check_eq("step_d1a", {31'd0, step_err}, 32'd0);
      drive(1'b1, 4'b0011);
      check_eq("step_d1b", {31'd0, step_err}, 32'd0);
      drive(1'b1, 4'b0000);
      check_eq("step_d2", {31'd0, step_err}, 32'd1);
      check_eq("step_d2_bin", {28'd0, binary}, 32'd0);
      drive(1'b1, 4'b1000);
      check_eq("step_to_msb", {31'd0, step_err}, 32'd0);
      drive(1'b1, 4'b0000);
      check_eq("step_wrap", {31'd0, step_err}, 32'd0);
      drive(1'b1, 4'b0000);
      check_eq("step_repeat", {31'd0, step_err}, 32'd0);
      drive(1'b1, 4'b0110);
      check_eq("step_d2b", {31'd0, step_err}, 32'd1);
      drive(1'b0, 4'b0000);
      check_eq("step_idle_clr", {31'd0, step_err}, 32'd0);
`endif

      // WIDTH=8 instance.
      @(negedge clk);
      in_valid  = 1'b0;
      in_valid8 = 1'b1;
      gray8     = 8'b1000_0000;
      @(posedge clk);
      #1;
      check_eq("w8_msb_bin", {24'd0, binary8}, {24'd0, 8'b1111_1111});
      check_eq("w8_msb_vld", {31'd0, out_valid8}, 32'd1);
      @(negedge clk);
      gray8 = 8'b1111_1111;
      @(posedge clk);
      #1;
      check_eq("w8_ones_bin", {24'd0, binary8}, {24'd0, 8'b1010_1010});
      @(negedge clk);
      in_valid8 = 1'b0;
      gray8     = 8'b0000_0001;
      @(posedge clk);
      #1;
      check_eq("w8_idle_vld", {31'd0, out_valid8}, 32'd0);
      check_eq("w8_idle_bin", {24'd0, binary8}, {24'd0, 8'b1010_1010});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
